// File: rtl/sevenseg_scan.sv
`default_nettype none
// ============================================================================
// Module      : sevenseg_scan
// Description : Multiplexed seven-segment display driver. Scans DIGITS hex
//               digits at REFRESH_DIV clocks per digit. A pending/display
//               register pair commits newly loaded values only at frame
//               boundaries. Per-digit blanking comes from blank_mask.
//               Optional macro SEVENSEG_LZ_BLANK_EN also suppresses leading
//               zeros. Digit 0 is never suppressed.
// Revision    : 1.0 - initial release
// ============================================================================
module sevenseg_scan #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value_i,
    input  logic                  load_i,
    input  logic [DIGITS-1:0]     blank_mask_i,
    output logic [6:0]            seg_o,
    output logic [DIGITS-1:0]     an_o,
    output logic                  frame_tick_o
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIV_W-1:0]  C_DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  C_IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [6:0]        C_SEG_OFF  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] C_AN_OFF   = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] pending_q, pending_d;
    logic [4*DIGITS-1:0] display_q, display_d;
    logic                wrap_q, wrap_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_tick_q, frame_tick_d;

    logic [DIGITS-1:0]   lz_mask;
    logic [3:0]          cur_nibble;
    logic                cur_blank;
    logic [6:0]          seg_act;
    logic [DIGITS-1:0]   an_act;

    // Hex to active-high segment pattern {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

`ifdef SEVENSEG_LZ_BLANK_EN
    // Suppress digits whose nibble and every higher nibble are zero (digit 0 kept)
    always_comb begin
        logic nz_above;
        lz_mask  = '0;
        nz_above = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            nz_above   = nz_above | (|display_q[4*i +: 4]);
            lz_mask[i] = ~nz_above;
        end
    end
`else
    assign lz_mask = '0;
`endif

    // Scan counters, load capture and frame-boundary commit
    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        idx_d     = idx_q;
        display_d = display_q;
        wrap_d    = 1'b0;
        pending_d = load_i ? value_i : pending_q;
        if (div_cnt_q == C_DIV_LAST) begin
            div_cnt_d = '0;
            if (idx_q == C_IDX_LAST) begin
                idx_d     = '0;
                display_d = pending_q;
                wrap_d    = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Select the current digit, apply blanking and output polarity
    always_comb begin
        cur_nibble = '0;
        cur_blank  = 1'b0;
        an_act     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nibble = display_q[4*i +: 4];
                cur_blank  = blank_mask_i[i] | lz_mask[i];
                an_act[i]  = 1'b1;
            end
        end
        seg_act = hex_decode(cur_nibble);
        if (cur_blank) begin
            seg_act = '0;
            an_act  = '0;
        end
        seg_d        = (ACTIVE_LOW != 0) ? ~seg_act : seg_act;
        an_d         = (ACTIVE_LOW != 0) ? ~an_act : an_act;
        // Delayed one cycle so the tick lines up with the first digit-0 pixels
        frame_tick_d = wrap_q;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q    <= '0;
            idx_q        <= '0;
            pending_q    <= '0;
            display_q    <= '0;
            wrap_q       <= 1'b0;
            seg_q        <= C_SEG_OFF;
            an_q         <= C_AN_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            display_q    <= display_d;
            wrap_q       <= wrap_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg_o        = seg_q;
    assign an_o         = an_q;
    assign frame_tick_o = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_sevenseg_scan
// Description : Self-checking bench for sevenseg_scan (DIGITS=4,
//               REFRESH_DIV=4, ACTIVE_LOW=1). A cycle-level reference model
//               derives slot and frame position arithmetically from the
//               number of clock edges since reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sevenseg_scan;

    localparam int DG = 4;
    localparam int RD = 4;
    localparam int FR = DG * RD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic [3:0]  blank_mask = '0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;

    sevenseg_scan #(.DIGITS(DG), .REFRESH_DIV(RD), .ACTIVE_LOW(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .value_i      (value),
        .load_i       (load),
        .blank_mask_i (blank_mask),
        .seg_o        (seg),
        .an_o         (an),
        .frame_tick_o (frame_tick)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_hi [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_edge   = 0;
    logic [15:0] m_pend   = '0;
    logic [15:0] m_disp   = '0;
    logic [3:0]  bm_cur   = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, n_edge);
        end
    endtask

    // One clock: drive inputs, advance the model, compare all outputs
    task automatic step(input logic r, input logic ld, input logic [15:0] v, input logic [3:0] bm);
        int         s;
        logic [3:0] nib;
        logic       blk;
        logic [6:0] es;
        logic [3:0] ea;
        logic       eft;
        @(negedge clk);
        rst = r; load = ld; value = v; blank_mask = bm;
        @(posedge clk);
        if (r) begin
            es = 7'h7F; ea = 4'hF; eft = 1'b0;
            n_edge = 0; m_disp = '0; m_pend = '0;
        end else begin
            s   = (n_edge / RD) % DG;
            nib = 4'((m_disp >> (4 * s)) & 16'hF);
            blk = bm[s];
`ifdef SEVENSEG_LZ_BLANK_EN
            if (s > 0 && (m_disp >> (4 * s)) == 16'h0) blk = 1'b1;
`endif
            es  = blk ? 7'h7F : ~seg_hi[nib];
            ea  = blk ? 4'hF : ~(4'b0001 << s);
            eft = (n_edge >= FR) && (n_edge % FR == 0);
            if (n_edge % FR == FR - 1) m_disp = m_pend;
            if (ld) m_pend = v;
            n_edge++;
        end
        #1;
        check("seg", 32'(seg), 32'(es));
        check("an", 32'(an), 32'(ea));
        check("frame_tick", 32'(frame_tick), 32'(eft));
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 16'h0, bm_cur);
    endtask

    task automatic to_boundary_cycle();
        for (int i = 0; i < FR && (n_edge % FR) != FR - 1; i++) step(1'b0, 1'b0, 16'h0, bm_cur);
    endtask

    initial begin
        logic       r_ld;
        logic [15:0] r_v;
        // Reset held for a few cycles, then release and watch a frame
        step(1'b1, 1'b0, 16'h0, 4'h0);
        step(1'b1, 1'b1, 16'hFFFF, 4'h0);
        step(1'b1, 1'b0, 16'h0, 4'h0);
        idle(FR + 4);
        check("first_frame_tick_seen", 32'(n_edge), 32'(FR + 4));

        // Load mid-frame: held back until the frame boundary
        step(1'b0, 1'b1, 16'h000D, bm_cur);
        idle(2 * FR);

        // Load on the exact frame-boundary cycle
        to_boundary_cycle();
        step(1'b0, 1'b1, 16'h0007, bm_cur);
        idle(2 * FR);

        // Two loads in one frame; only the last is shown
        step(1'b0, 1'b1, 16'h1234, bm_cur);
        step(1'b0, 1'b0, 16'h0, bm_cur);
        step(1'b0, 1'b1, 16'hABCD, bm_cur);
        idle(2 * FR);

        // Blank digit 2 while showing 8888
        step(1'b0, 1'b1, 16'h8888, bm_cur);
        idle(FR);
        bm_cur = 4'b0100;
        idle(2 * FR);
        bm_cur = 4'b0000;
        idle(4);

        // Reset during the digit-2 slot
        for (int i = 0; i < FR && ((n_edge / RD) % DG) != 2; i++) step(1'b0, 1'b0, 16'h0, bm_cur);
        step(1'b1, 1'b0, 16'h0, bm_cur);
        idle(2 * FR);

        // Randomized traffic with occasional mask changes and resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) bm_cur = 4'($urandom);
            r_ld = ($urandom_range(0, 9) == 0);
            r_v  = 16'($urandom);
            if ((r_v & 16'h000F) == 16'h0 && $urandom_range(0, 1) == 0) r_v = r_v & 16'h00FF;
            step(($urandom_range(0, 199) == 0), r_ld, r_v, bm_cur);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
